// File: rtl/rf_pkg.sv
// Shared constants, FSM state type and address-legality helper for the register-file write arbiter.
package rf_pkg;

    localparam int RF_DW    = 24;
    localparam int RF_AW    = 4;
    localparam int RF_NREGS = 11;
    localparam logic [RF_AW-1:0] R11_ADDR = 4'd11;

    typedef enum logic {INIT, RUN} rf_wr_state_t;

    // r11 is supplied from outside the file and is never writable, whatever nregs says
    function automatic logic wr_addr_legal(input logic [RF_AW-1:0] addr, input int nregs);
        return (addr != R11_ADDR) && (int'(addr) < nregs);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    always_comb begin
        gnt = '0;
        idx = '0;
        // walk from farthest to nearest so the nearest active request is assigned last
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx = PW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between NREQ writeback sources and clears the file after reset.
// Optional dropped-write counter on err_cnt when RF_WR_ERRCNT_EN is defined.
//
// state | meaning
// INIT  | sweep writes 0 to r0..r(NREGS-1), requesters held off
// RUN   | round-robin arbitration of writeback requests
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int NREGS = RF_NREGS,
    parameter int DW    = RF_DW,
    parameter int AW    = RF_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wa,
    output logic [DW-1:0]      rf_wd,
    output logic               init_busy,
`ifdef RF_WR_ERRCNT_EN
    output logic [7:0]         err_cnt,
`endif
    output logic               illegal
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    rf_wr_state_t    state;
    logic [AW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   idx;
    logic            grant;
    logic            legal;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx)
    );

    assign grant     = (state == RUN) && (|req_valid);
    assign req_ready = grant ? gnt : '0;
    assign sel_addr  = req_addr[int'(idx)*AW +: AW];
    assign sel_data  = req_data[int'(idx)*DW +: DW];
    assign legal     = wr_addr_legal(sel_addr, NREGS);
    assign init_busy = (state == INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= '0;
            ptr     <= '0;
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    illegal <= 1'b0;
                    if (cnt == AW'(NREGS)) begin
                        rf_we <= 1'b0;
                        state <= RUN;
                    end else begin
                        rf_we <= 1'b1;
                        rf_wa <= cnt;
                        rf_wd <= '0;
                        cnt   <= cnt + AW'(1);
                    end
                end
                RUN: begin
                    // illegal targets are still accepted so the requester never stalls
                    rf_we   <= grant && legal;
                    illegal <= grant && !legal;
                    if (grant) begin
                        ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + PW'(1);
                        if (legal) begin
                            rf_wa <= sel_addr;
                            rf_wd <= sel_data;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef RF_WR_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (state == RUN && grant && !legal && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: sweep, directed vector table, fairness, reset mid-sweep, random vs reference model.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [7:0]  req_addr = '0;
    logic [47:0] req_data = '0;
    logic [1:0]  req_ready;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [23:0] rf_wd;
    logic        init_busy;
    logic        illegal;
`ifdef RF_WR_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int nerr = 0;
    int nchk = 0;

    rf_write_arbiter #(.NREQ(2), .NREGS(11), .DW(24), .AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .init_busy (init_busy),
`ifdef RF_WR_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // register file: writes on the falling edge from the registered port
    logic [23:0] file_q [11];
    always @(negedge clk) begin
        if (rf_we && rf_wa < 4'd11) file_q[rf_wa] <= rf_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [1:0]  last_v, last_r;
    logic [7:0]  last_a;
    logic [47:0] last_d;
    bit          hist = 0;

    // called at posedge+1; returns ready seen before the edge, leaves time at next posedge+1
    task automatic drive(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [23:0] d0, input logic [23:0] d1, output logic [1:0] rdy);
        logic [7:0]  na;
        logic [47:0] nd;
        na = {a1, a0};
        nd = {d1, d0};
        if (hist) begin
            for (int i = 0; i < 2; i++) begin
                if (last_v[i] && !last_r[i]) begin
                    assert (v[i] && na[i*4 +: 4] == last_a[i*4 +: 4] && nd[i*24 +: 24] == last_d[i*24 +: 24])
                    else $error("FAIL req_stable: requester %0d changed before ready", i);
                end
            end
        end
        req_valid = v;
        req_addr  = na;
        req_data  = nd;
        #1;
        rdy = req_ready;
        last_v = v; last_a = na; last_d = nd; last_r = rdy; hist = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0; req_addr = '0; req_data = '0; hist = 0;
        rst = 1'b1;
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_wa", rf_wa, 0);
        chk("rst_wd", rf_wd, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_busy", init_busy, 1);
        chk("rst_ready", req_ready, 0);
`ifdef RF_WR_ERRCNT_EN
        chk("rst_errcnt", err_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // hold=1 keeps requester 0 asking for (3, ABCDEF) throughout the sweep
    task automatic sweep(input bit hold);
        logic [1:0] r;
        for (int c = 0; c < 12; c++) begin
            if (hold) drive(2'b01, 4'd3, 4'd0, 24'hABCDEF, 24'h0, r);
            else      drive(2'b00, 4'd0, 4'd0, 24'h0, 24'h0, r);
            chk("sweep_ready", r, 0);
            if (c < 11) begin
                chk("sweep_we", rf_we, 1);
                chk("sweep_wa", rf_wa, c);
                chk("sweep_wd", rf_wd, 0);
                chk("sweep_busy", init_busy, 1);
            end else begin
                chk("sweep_end_we", rf_we, 0);
                chk("sweep_end_busy", init_busy, 0);
            end
        end
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [3:0]  a0, a1;
        logic [23:0] d0, d1;
        logic [1:0]  rdy;
        logic        we;
        logic [3:0]  wa;
        logic [23:0] wd;
        logic        ill;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r;
        logic [23:0] c0, c1;
        bit          pend [2];
        logic [3:0]  pa [2];
        logic [23:0] pd [2];
        logic [23:0] mem_m [11];
        int          ptr_m, g, errm, maxw;
        int          waitc [2];
        logic        ew, eill;
        logic [3:0]  ewa;
        logic [23:0] ewd;
        logic [1:0]  er;

        tbl[0]  = '{2'b01, 4'd3,  4'd0,  24'hABCDEF, 24'h0,  2'b01, 1'b1, 4'd3,  24'hABCDEF, 1'b0};
        tbl[1]  = '{2'b11, 4'd4,  4'd6,  24'h11,     24'h22, 2'b10, 1'b1, 4'd6,  24'h22,     1'b0};
        tbl[2]  = '{2'b11, 4'd4,  4'd7,  24'h11,     24'h33, 2'b01, 1'b1, 4'd4,  24'h11,     1'b0};
        tbl[3]  = '{2'b10, 4'd4,  4'd7,  24'h11,     24'h33, 2'b10, 1'b1, 4'd7,  24'h33,     1'b0};
        tbl[4]  = '{2'b10, 4'd0,  4'd11, 24'h0,      24'h44, 2'b10, 1'b0, 4'd7,  24'h33,     1'b1};
        tbl[5]  = '{2'b10, 4'd0,  4'd15, 24'h0,      24'h55, 2'b10, 1'b0, 4'd7,  24'h33,     1'b1};
        tbl[6]  = '{2'b00, 4'd0,  4'd0,  24'h0,      24'h0,  2'b00, 1'b0, 4'd7,  24'h33,     1'b0};
        tbl[7]  = '{2'b11, 4'd5,  4'd5,  24'h1,      24'h2,  2'b01, 1'b1, 4'd5,  24'h1,      1'b0};
        tbl[8]  = '{2'b10, 4'd0,  4'd5,  24'h0,      24'h2,  2'b10, 1'b1, 4'd5,  24'h2,      1'b0};
        tbl[9]  = '{2'b01, 4'd10, 4'd0,  24'hFFFFFF, 24'h0,  2'b01, 1'b1, 4'd10, 24'hFFFFFF, 1'b0};
        tbl[10] = '{2'b00, 4'd0,  4'd0,  24'h0,      24'h0,  2'b00, 1'b0, 4'd10, 24'hFFFFFF, 1'b0};

        #1;
        // sweep with a request held off, then the directed table
        do_reset();
        sweep(1);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, r);
            chk($sformatf("tbl%0d_ready", i), r, tbl[i].rdy);
            chk($sformatf("tbl%0d_we", i), rf_we, tbl[i].we);
            chk($sformatf("tbl%0d_wa", i), rf_wa, tbl[i].wa);
            chk($sformatf("tbl%0d_wd", i), rf_wd, tbl[i].wd);
            chk($sformatf("tbl%0d_illegal", i), illegal, tbl[i].ill);
        end
        @(negedge clk);
        #1;
        chk("file_r3", file_q[3], 24'hABCDEF);
        chk("file_r5_race", file_q[5], 24'h2);
        chk("file_r6", file_q[6], 24'h22);
        chk("file_r10", file_q[10], 24'hFFFFFF);
        chk("file_r0_cleared", file_q[0], 24'h0);
`ifdef RF_WR_ERRCNT_EN
        chk("errcnt_after_table", err_cnt, 2);
`endif
        @(posedge clk);
        #1;

        // reset in the middle of the sweep
        do_reset();
        for (int c = 0; c < 5; c++) drive(2'b00, 4'd0, 4'd0, 24'h0, 24'h0, r);
        chk("midsweep_wa", rf_wa, 4);
        #2;
        do_reset();
        sweep(0);

        // fairness with both requesters continuously valid
        do_reset();
        sweep(0);
        c0 = 24'h100; c1 = 24'h200;
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, 4'd1, 4'd2, c0, c1, r);
            chk("rr_grant", r, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_wa", rf_wa, (k % 2 == 0) ? 4'd1 : 4'd2);
            chk("rr_wd", rf_wd, (k % 2 == 0) ? c0 : c1);
            if (r[0]) c0 = c0 + 24'd1;
            if (r[1]) c1 = c1 + 24'd1;
        end

        // random traffic against the reference model
        do_reset();
        sweep(0);
        ptr_m = 0; errm = 0; maxw = 0;
        ew = 0; eill = 0; ewa = 4'd10; ewd = 24'h0;
        for (int i = 0; i < 11; i++) mem_m[i] = 24'h0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; pa[i] = 0; pd[i] = 0; waitc[i] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 7) begin
                    pend[i] = 1;
                    pa[i] = 4'($urandom_range(0, 15));
                    pd[i] = 24'($urandom);
                end
            end
            g = -1;
            for (int k = 0; k < 2; k++) begin
                if (g < 0 && pend[(ptr_m + k) % 2]) g = (ptr_m + k) % 2;
            end
            er = (g >= 0) ? 2'(1 << g) : 2'b00;
            drive({pend[1], pend[0]}, pa[0], pa[1], pd[0], pd[1], r);
            chk("rand_ready", r, er);
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && i != g) begin
                    waitc[i]++;
                    if (waitc[i] > maxw) maxw = waitc[i];
                end else begin
                    waitc[i] = 0;
                end
            end
            ew = 0; eill = 0;
            if (g >= 0) begin
                pend[g] = 0;
                ptr_m = (g + 1) % 2;
                if (pa[g] < 4'd11) begin
                    ew = 1; ewa = pa[g]; ewd = pd[g];
                    mem_m[pa[g]] = pd[g];
                end else begin
                    eill = 1;
                    if (errm < 255) errm++;
                end
            end
            chk("rand_we", rf_we, ew);
            chk("rand_wa", rf_wa, ewa);
            chk("rand_wd", rf_wd, ewd);
            chk("rand_illegal", illegal, eill);
        end
        chk("rand_max_wait", maxw, 1);
        @(negedge clk);
        #1;
        for (int i = 0; i < 11; i++) chk($sformatf("rand_file_r%0d", i), file_q[i], mem_m[i]);
`ifdef RF_WR_ERRCNT_EN
        chk("rand_errcnt", err_cnt, errm);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
